// File: rtl/weight_loader.sv
// weight_loader: streams one model's weight words from the shared ROM
// into the accelerator weight bank on each reload request.
module weight_loader #(
  parameter  int NUM_WORDS = 16,
  parameter  int WORD_W    = 32,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload_weights,
  input  logic [1:0]        active_model,
  input  logic              compute_busy,
  output logic              mem_rd_en,
  output logic [IDX_W:0]    mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              wb_wr_en,
  output logic [IDX_W-1:0]  wb_addr,
  output logic [WORD_W-1:0] wb_data,
  output logic              busy,
  output logic              weights_ready,
  output logic [1:0]        loaded_model,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_bank;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_idx_q;
  logic               r_rd_valid;
  logic               r_ready;
  logic [1:0]         r_loaded;
  logic               r_err;
  logic               w_valid;
  logic               w_last;
  logic               w_done;
  logic [1:0]         w_model;

  assign w_valid = reload_weights &
                   ((active_model == 2'b01) |
                    (active_model == 2'b10));
  assign w_last  = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign w_model = r_bank ? 2'b10 : 2'b01;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and strobes; a valid reload overrides everything
  always_comb begin
    w_next    = r_state;
    mem_rd_en = 1'b0;
    busy      = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_WAIT: begin
        busy = 1'b1;
        if (!compute_busy) w_next = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_valid) begin
      w_next = compute_busy ? S_WAIT : S_FETCH;
      w_done = 1'b0;
    end
  end

  // Index, read-valid pipe and completion status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank     <= 1'b0;
      r_idx      <= '0;
      r_idx_q    <= '0;
      r_rd_valid <= 1'b0;
      r_ready    <= 1'b0;
      r_loaded   <= 2'b00;
      r_err      <= 1'b0;
    end else begin
      r_err      <= reload_weights & ~w_valid;
      r_rd_valid <= mem_rd_en & ~w_valid;
      r_idx_q    <= r_idx;
      if (w_valid) begin
        r_bank   <= active_model[1];
        r_idx    <= '0;
        r_ready  <= 1'b0;
        r_loaded <= 2'b00;
      end else begin
        if (mem_rd_en) r_idx <= r_idx + 1'b1;
        if (w_done) begin
          r_ready  <= 1'b1;
          r_loaded <= w_model;
        end
      end
    end
  end

  assign mem_addr      = {r_bank, r_idx};
  assign wb_wr_en      = r_rd_valid;
  assign wb_addr       = r_idx_q;
  assign wb_data       = mem_rdata;
  assign load_done     = w_done;
  assign weights_ready = r_ready | w_done;
  assign loaded_model  = w_done ? w_model : r_loaded;
  assign load_err      = r_err;

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed and random reload traffic against
// a load-job level reference model of weight_loader.
module tb_weight_loader;
  localparam int N  = 16;
  localparam int W  = 32;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          reload_weights;
  logic [1:0]    active_model;
  logic          compute_busy;
  logic          mem_rd_en;
  logic [IW:0]   mem_addr;
  logic [W-1:0]  mem_rdata;
  logic          wb_wr_en;
  logic [IW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          busy;
  logic          weights_ready;
  logic [1:0]    loaded_model;
  logic          load_done;
  logic          load_err;

  logic [W-1:0] rom [2*N];
  logic [W-1:0] img [N];

  int n_chk = 0;
  int n_err = 0;

  bit       m_act;
  bit       m_wait;
  int       m_t;
  bit       m_bank;
  bit       m_ready;
  bit [1:0] m_loaded;
  bit       m_err;

  weight_loader #(.NUM_WORDS(N), .WORD_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .reload_weights(reload_weights),
    .active_model(active_model),
    .compute_busy(compute_busy),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .wb_wr_en(wb_wr_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .busy(busy),
    .weights_ready(weights_ready),
    .loaded_model(loaded_model),
    .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= rom[mem_addr];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic rl,
                      input logic [1:0] am, input logic cb,
                      input bit on);
    bit v, e_rd, e_wr, e_done, e_busy, e_ready;
    bit [1:0] e_model;
    int base;
    @(negedge clk);
    rst = r;
    reload_weights = rl;
    active_model = am;
    compute_busy = cb;
    #1;
    v       = rl && (am == 2'b01 || am == 2'b10);
    base    = m_bank ? N : 0;
    e_rd    = m_act && !m_wait && m_t < N;
    e_wr    = m_act && !m_wait && m_t >= 1 && m_t <= N;
    e_done  = m_act && !m_wait && m_t == N + 1 && !v;
    e_busy  = m_act && (m_wait || m_t <= N);
    e_ready = m_ready || e_done;
    e_model = e_done ? (m_bank ? 2'b10 : 2'b01) : m_loaded;
    if (on) begin
      chk("rd_en", 32'(mem_rd_en), 32'(e_rd));
      if (e_rd)
        chk("mem_addr", 32'(mem_addr), 32'(base + m_t));
      chk("wr_en", 32'(wb_wr_en), 32'(e_wr));
      if (e_wr) begin
        chk("wb_addr", 32'(wb_addr), 32'(m_t - 1));
        chk("wb_data", wb_data, rom[base + m_t - 1]);
      end
      chk("busy", 32'(busy), 32'(e_busy));
      chk("ready", 32'(weights_ready), 32'(e_ready));
      chk("model", 32'(loaded_model), 32'(e_model));
      chk("done", 32'(load_done), 32'(e_done));
      chk("err", 32'(load_err), 32'(m_err));
    end
    if (wb_wr_en === 1'b1) img[wb_addr] = wb_data;
    if (on && e_done)
      for (int i = 0; i < N; i++)
        chk($sformatf("img%0d", i), img[i], rom[base + i]);
    @(posedge clk);
    if (r) begin
      m_act = 0; m_wait = 0; m_t = 0; m_bank = 0;
      m_ready = 0; m_loaded = 0; m_err = 0;
    end else begin
      m_err = rl && !v;
      if (v) begin
        m_act = 1; m_wait = cb; m_t = 0;
        m_bank = am[1]; m_ready = 0; m_loaded = 0;
      end else if (m_act) begin
        if (m_wait) m_wait = cb;
        else if (m_t == N + 1) begin
          m_act = 0; m_ready = 1;
          m_loaded = m_bank ? 2'b10 : 2'b01;
        end else m_t++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 2'b00, 0, 1);
  endtask

  initial begin
    bit cb_r;
    bit r, rl;
    logic [1:0] am;
    for (int i = 0; i < 2*N; i++) rom[i] = $urandom;
    for (int i = 0; i < N; i++) img[i] = '0;
    m_act = 0; m_wait = 0; m_t = 0; m_bank = 0;
    m_ready = 0; m_loaded = 0; m_err = 0;
    step(1, 0, 2'b00, 0, 0);
    step(1, 0, 2'b00, 0, 1);
    idle(2);
    // Load A, no stall
    step(0, 1, 2'b01, 0, 1);
    idle(20);
    // Load B
    step(0, 1, 2'b10, 0, 1);
    idle(20);
    // Compute busy holds the load off for 5 cycles
    step(0, 1, 2'b01, 1, 1);
    repeat (4) step(0, 0, 2'b00, 1, 1);
    idle(22);
    // Abort A at index 7 with a reload of B
    step(0, 1, 2'b01, 0, 1);
    idle(7);
    step(0, 1, 2'b10, 0, 1);
    idle(20);
    // Invalid model while A is loaded
    step(0, 1, 2'b01, 0, 1);
    idle(20);
    step(0, 1, 2'b00, 0, 1);
    idle(3);
    step(0, 1, 2'b11, 0, 1);
    idle(3);
    // Reset at index 9
    step(0, 1, 2'b01, 0, 1);
    idle(9);
    step(1, 0, 2'b00, 0, 1);
    idle(20);
    // Reload in the DONE cycle wins over completion
    step(0, 1, 2'b01, 0, 1);
    idle(17);
    step(0, 1, 2'b10, 0, 1);
    idle(20);
    // Random traffic
    cb_r = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) cb_r = ~cb_r;
      r  = ($urandom_range(0, 299) == 0);
      rl = ($urandom_range(0, 29) == 0);
      am = 2'($urandom_range(0, 3));
      step(r, rl, am, cb_r, 1);
    end
    idle(25);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
